fft8_input_buffer: RTL

FFT8_INPUT_BUFFER -- requirements
Module: fft8_input_buffer

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_ram16.sv | 27 ++
 rtl/fft8_input_buffer.sv | 98 +++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the 8-point FFT front end: default sample width,
// frame length and the stride order used to pair x(n) with x(n+4).
package fft_pkg;

  localparam int TOTAL_BITS = 32;
  localparam int FRAME_LEN  = 8;
  localparam int ADDR_W     = $clog2(FRAME_LEN);
  localparam int CNT_W      = ADDR_W + 1;

  // Entry [k] is the bank address emitted as output word k: 0,4,1,5,2,6,3,7.
  localparam logic [FRAME_LEN-1:0][ADDR_W-1:0] READ_ORDER =
    {3'd7, 3'd3, 3'd6, 3'd2, 3'd5, 3'd1, 3'd4, 3'd0};

endpackage

// File: rtl/fft_ram16.sv
// Two 8-word ping-pong banks in one 16-word array: one synchronous write
// port and one registered read port, both qualified by their enables.
module fft_ram16 #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         we_i,
  input  logic [3:0]   waddr_i,
  input  logic [W-1:0] wdata_i,
  input  logic         re_i,
  input  logic [3:0]   raddr_i,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem_q [16];
  logic [W-1:0] rdata_q;

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM
  // cells; nothing downstream consumes a word before it has been written.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft8_input_buffer.sv
// Ping-pong input buffer for an 8-point radix-2 FFT: captures frames in
// natural order and replays each finished frame in butterfly stride order.
module fft8_input_buffer
  import fft_pkg::*;
#(
  parameter int total_bits = TOTAL_BITS
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         ED,
  input  logic                         START,
  input  logic signed [total_bits-1:0] DR,
  input  logic signed [total_bits-1:0] DI,
  output logic                         RDY,
  output logic signed [total_bits-1:0] DOR,
  output logic signed [total_bits-1:0] DOI
);

  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, wr_addr;
  logic              wr_en;
  logic              started_q, started_d;
  logic [1:0]        full_q, full_d;
  logic              rd_active_q, rd_active_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_vld_q, rd_first_q;
  logic              rdy_q;
  logic signed [total_bits-1:0] dor_q, doi_q;
  logic [2*total_bits-1:0]      ram_rdata;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    wr_en     = START | started_q;
    wr_addr   = START ? {wr_cnt_q[ADDR_W], {ADDR_W{1'b0}}} : wr_cnt_q;
    wr_cnt_d  = wr_addr + CNT_W'(1);
    started_d = started_q | START;

    full_d = full_q;
    if (START) full_d[wr_addr[ADDR_W]] = 1'b0;
    if (wr_en && wr_addr[ADDR_W-1:0] == ADDR_W'(FRAME_LEN-1))
      full_d[wr_addr[ADDR_W]] = 1'b1;

    rd_cnt_d    = rd_cnt_q + ADDR_W'(1);
    rd_active_d = rd_active_q && (rd_cnt_q != ADDR_W'(FRAME_LEN-1));
    rd_bank_d   = rd_bank_q;
    // A finished bank starts its pass on the edge after its last write,
    // seamlessly following a pass that ends on that same edge.
    if (!rd_active_d && full_d != 2'b00) begin
      rd_bank_d         = full_d[~rd_bank_q] ? ~rd_bank_q : rd_bank_q;
      full_d[rd_bank_d] = 1'b0;
      rd_active_d       = 1'b1;
      rd_cnt_d          = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_cnt_q    <= '0;
      started_q   <= 1'b0;
      full_q      <= '0;
      rd_active_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_first_q  <= 1'b0;
      rdy_q       <= 1'b0;
      dor_q       <= '0;
      doi_q       <= '0;
    end else if (ED) begin
      if (wr_en) wr_cnt_q <= wr_cnt_d;
      started_q   <= started_d;
      full_q      <= full_d;
      rd_active_q <= rd_active_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_vld_q    <= rd_active_q;
      rd_first_q  <= rd_active_q && (rd_cnt_q == '0);
      rdy_q       <= rd_vld_q && rd_first_q;
      if (rd_vld_q) {dor_q, doi_q} <= ram_rdata;
    end
  end

  fft_ram16 #(.W(2*total_bits)) u_ram (
    .clk_i   (CLK),
    .we_i    (ED & wr_en),
    .waddr_i (wr_addr),
    .wdata_i ({DR, DI}),
    .re_i    (ED & rd_active_q),
    .raddr_i ({rd_bank_q, READ_ORDER[rd_cnt_q]}),
    .rdata_o (ram_rdata)
  );

  assign RDY = rdy_q;
  assign DOR = dor_q;
  assign DOI = doi_q;

endmodule
